// File: rtl/mmio_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mmio_arbiter_pkg
//   Shared types and constants for the MMIO arbiter.
//   - mmio_arbiter_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   - mmio_channel_t       : upstream channel identifier (READ, WRITE)
//   - AXI4_LITE_*_WIDTH    : default address/data widths of the AXI4-Lite side
//   - MMIO_TIMEOUT_DATA_DEFAULT : read data returned by a timed-out read
// -----------------------------------------------------------------------------
package mmio_arbiter_pkg;

    localparam int AXI4_LITE_ADDRESS_WIDTH = 32;
    localparam int AXI4_LITE_DATA_WIDTH    = 32;

    localparam logic [31:0] MMIO_TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mmio_arbiter_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mmio_channel_t;

    // Round-robin helper: the channel that gets priority after a grant.
    function automatic mmio_channel_t other_channel(input mmio_channel_t channel);
        return (channel == READ) ? WRITE : READ;
    endfunction

endpackage

// File: rtl/mmio_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// mmio_watchdog
//   Transaction watchdog for mmio_arbiter. Only compiled when the macro
//   MMIO_ARBITER_TIMEOUT_EN is defined.
//   Ports:
//     clk     : clock, positive edge
//     rst_n   : asynchronous active-low reset
//     clear   : synchronous clear of the cycle counter
//     enable  : count this cycle (arbiter is waiting on the target)
//     expired : this enabled cycle is the TIMEOUT_CYCLES-th since clear
// -----------------------------------------------------------------------------
`ifdef MMIO_ARBITER_TIMEOUT_EN
module mmio_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds the number of enabled cycles already completed, so
    // the TIMEOUT_CYCLES-th enabled cycle sees TIMEOUT_CYCLES-1 and expires
    // in that same cycle, letting the arbiter leave BUSY on its edge.
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + COUNT_WIDTH'(1);
        end
    end

    assign expired = enable && (count_reg == LAST_COUNT);

endmodule
`endif

// File: rtl/mmio_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_arbiter
//   Shares one downstream req/ack MMIO port between the read and write
//   request channels of the AXI4-Lite slave. Round-robin arbitration, one
//   transaction outstanding, single-cycle registered ack to the winner.
//   Optional watchdog (macro MMIO_ARBITER_TIMEOUT_EN) forces completion of a
//   transaction after TIMEOUT_CYCLES cycles in BUSY.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESETN        : clock, async active-low reset
//     read_req/read_address            : upstream read request (held to ack)
//     read_ack/read_data               : read completion pulse + held data
//     write_req/write_address/write_data : upstream write request
//     write_ack                        : write completion pulse
//     mmio_req/mmio_write/mmio_address/mmio_wdata : downstream request
//     mmio_ack/mmio_rdata              : downstream completion + read data
//     timeout_error/timeout_clear      : sticky timeout flag and its clear
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = AXI4_LITE_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = AXI4_LITE_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(MMIO_TIMEOUT_DATA_DEFAULT)
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic                     read_req,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic                     read_ack,
    output logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     write_req,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_ack,
    output logic                     mmio_req,
    output logic                     mmio_write,
    output logic [ADDRESS_WIDTH-1:0] mmio_address,
    output logic [DATA_WIDTH-1:0]    mmio_wdata,
    input  logic                     mmio_ack,
    input  logic [DATA_WIDTH-1:0]    mmio_rdata,
    output logic                     timeout_error,
    input  logic                     timeout_clear
);

    mmio_arbiter_state_t       state_reg, state_next;
    mmio_channel_t             pointer_reg, pointer_next;
    mmio_channel_t             grant_reg, grant_next;
    mmio_channel_t             winner;
    logic                      mmio_req_reg, mmio_req_next;
    logic                      mmio_write_reg, mmio_write_next;
    logic [ADDRESS_WIDTH-1:0]  mmio_address_reg, mmio_address_next;
    logic [DATA_WIDTH-1:0]     mmio_wdata_reg, mmio_wdata_next;
    logic [DATA_WIDTH-1:0]     read_data_reg, read_data_next;
    logic                      read_ack_reg, read_ack_next;
    logic                      write_ack_reg, write_ack_next;
    logic                      complete;

`ifdef MMIO_ARBITER_TIMEOUT_EN
    logic                      expired;
    logic                      timeout_error_reg, timeout_error_next;

    mmio_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .clear   (state_reg != BUSY),
        .enable  (state_reg == BUSY),
        .expired (expired)
    );

    // A target ack in the expiry cycle wins: it is a normal completion.
    assign complete = mmio_ack || expired;
`else
    logic                      unused_timeout_cfg;

    assign complete           = mmio_ack;
    assign unused_timeout_cfg = timeout_clear ^ (^TIMEOUT_DATA) ^ (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_next        = state_reg;
        pointer_next      = pointer_reg;
        grant_next        = grant_reg;
        mmio_req_next     = mmio_req_reg;
        mmio_write_next   = mmio_write_reg;
        mmio_address_next = mmio_address_reg;
        mmio_wdata_next   = mmio_wdata_reg;
        read_data_next    = read_data_reg;
        read_ack_next     = 1'b0;
        write_ack_next    = 1'b0;
        winner            = pointer_reg;
`ifdef MMIO_ARBITER_TIMEOUT_EN
        // Clear first so that a timeout in the same cycle overrides it.
        timeout_error_next = timeout_error_reg && !timeout_clear;
`endif

        case (state_reg)
            IDLE: begin
                if (read_req && !write_req) begin
                    winner = READ;
                end else if (write_req && !read_req) begin
                    winner = WRITE;
                end
                if (read_req || write_req) begin
                    grant_next        = winner;
                    mmio_req_next     = 1'b1;
                    mmio_write_next   = (winner == WRITE);
                    mmio_address_next = (winner == WRITE) ? write_address : read_address;
                    if (winner == WRITE) begin
                        mmio_wdata_next = write_data;
                    end
                    pointer_next      = other_channel(winner);
                    state_next        = BUSY;
                end
            end

            BUSY: begin
                if (complete) begin
                    mmio_req_next = 1'b0;
                    state_next    = RESP;
                    // The ack is registered here so it is high during RESP.
                    if (grant_reg == READ) begin
                        read_ack_next  = 1'b1;
                        read_data_next = mmio_ack ? mmio_rdata : TIMEOUT_DATA;
                    end else begin
                        write_ack_next = 1'b1;
                    end
`ifdef MMIO_ARBITER_TIMEOUT_EN
                    if (!mmio_ack) begin
                        timeout_error_next = 1'b1;
                    end
`endif
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg        <= IDLE;
            pointer_reg      <= WRITE;
            grant_reg        <= READ;
            mmio_req_reg     <= 1'b0;
            mmio_write_reg   <= 1'b0;
            mmio_address_reg <= '0;
            mmio_wdata_reg   <= '0;
            read_data_reg    <= '0;
            read_ack_reg     <= 1'b0;
            write_ack_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pointer_reg      <= pointer_next;
            grant_reg        <= grant_next;
            mmio_req_reg     <= mmio_req_next;
            mmio_write_reg   <= mmio_write_next;
            mmio_address_reg <= mmio_address_next;
            mmio_wdata_reg   <= mmio_wdata_next;
            read_data_reg    <= read_data_next;
            read_ack_reg     <= read_ack_next;
            write_ack_reg    <= write_ack_next;
        end
    end

`ifdef MMIO_ARBITER_TIMEOUT_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            timeout_error_reg <= 1'b0;
        end else begin
            timeout_error_reg <= timeout_error_next;
        end
    end

    assign timeout_error = timeout_error_reg;
`else
    assign timeout_error = 1'b0;
`endif

    assign mmio_req     = mmio_req_reg;
    assign mmio_write   = mmio_write_reg;
    assign mmio_address = mmio_address_reg;
    assign mmio_wdata   = mmio_wdata_reg;
    assign read_data    = read_data_reg;
    assign read_ack     = read_ack_reg;
    assign write_ack    = write_ack_reg;

endmodule

// File: tb/tb_mmio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmio_arbiter
//   Directed self-checking bench for mmio_arbiter. The DUT is built with
//   TIMEOUT_CYCLES = 16; the timeout scenario runs only when
//   MMIO_ARBITER_TIMEOUT_EN is defined, otherwise the no-ack case checks that
//   BUSY waits indefinitely and timeout_error stays 0.
// -----------------------------------------------------------------------------
module tb_mmio_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          read_req;
    logic [AW-1:0] read_address;
    logic          read_ack;
    logic [DW-1:0] read_data;
    logic          write_req;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          write_ack;
    logic          mmio_req;
    logic          mmio_write;
    logic [AW-1:0] mmio_address;
    logic [DW-1:0] mmio_wdata;
    logic          mmio_ack;
    logic [DW-1:0] mmio_rdata;
    logic          timeout_error;
    logic          timeout_clear;

    int checks = 0;
    int errors = 0;

    mmio_arbiter #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .read_req      (read_req),
        .read_address  (read_address),
        .read_ack      (read_ack),
        .read_data     (read_data),
        .write_req     (write_req),
        .write_address (write_address),
        .write_data    (write_data),
        .write_ack     (write_ack),
        .mmio_req      (mmio_req),
        .mmio_write    (mmio_write),
        .mmio_address  (mmio_address),
        .mmio_wdata    (mmio_wdata),
        .mmio_ack      (mmio_ack),
        .mmio_rdata    (mmio_rdata),
        .timeout_error (timeout_error),
        .timeout_clear (timeout_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n         = 1'b0;
        read_req      = 1'b0;
        write_req     = 1'b0;
        read_address  = '0;
        write_address = '0;
        write_data    = '0;
        mmio_ack      = 1'b0;
        mmio_rdata    = '0;
        timeout_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [2*AW+2*DW+4:0] all_outputs();
        return {mmio_req, mmio_write, mmio_address, mmio_wdata,
                read_ack, write_ack, read_data, timeout_error};
    endfunction

    task automatic test_reset;
        apply_reset();
        checks++; if (all_outputs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_outputs()); end
        tick();
        checks++; if (mmio_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b expected 0", mmio_req); end
    endtask

    task automatic test_single_read;
        int acks_r = 0;
        int acks_w = 0;
        apply_reset();
        read_address = 32'h0000_0040;
        read_req     = 1'b1;
        tick(); // cycle 1
        checks++; if (mmio_req !== 1'b1) begin errors++; $display("FAIL rd_mmio_req: got %b expected 1", mmio_req); end
        checks++; if (mmio_write !== 1'b0) begin errors++; $display("FAIL rd_mmio_write: got %b expected 0", mmio_write); end
        checks++; if (mmio_address !== 32'h40) begin errors++; $display("FAIL rd_mmio_address: got %h expected 40", mmio_address); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (read_ack) acks_r++;
            if (write_ack) acks_w++;
        end
        mmio_ack   = 1'b1; // cycle 4: target acks 3 cycles after mmio_req rose
        mmio_rdata = 32'h0000_1234;
        tick(); // cycle 5
        checks++; if (read_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_pulse: got %b expected 1", read_ack); end
        checks++; if (read_data !== 32'h1234) begin errors++; $display("FAIL rd_data: got %h expected 00001234", read_data); end
        checks++; if (mmio_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b expected 0", mmio_req); end
        if (read_ack) acks_r++;
        if (write_ack) acks_w++;
        mmio_ack   = 1'b0;
        read_req   = 1'b0;
        mmio_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (read_ack) acks_r++;
            if (write_ack) acks_w++;
        end
        checks++; if (read_data !== 32'h1234) begin errors++; $display("FAIL rd_data_hold: got %h expected 00001234", read_data); end
        checks++; if (acks_r !== 1) begin errors++; $display("FAIL rd_ack_count: got %0d expected 1", acks_r); end
        checks++; if (acks_w !== 0) begin errors++; $display("FAIL rd_write_ack_count: got %0d expected 0", acks_w); end
        $display("txn single_read addr=40 data=%h", read_data);
    endtask

    task automatic test_both_from_reset;
        apply_reset();
        write_address = 32'h0000_0080;
        write_data    = 32'hCAFE_0001;
        read_address  = 32'h0000_0044;
        write_req     = 1'b1;
        read_req      = 1'b1;
        tick(); // cycle 1: write wins from reset
        checks++; if (mmio_write !== 1'b1) begin errors++; $display("FAIL both_first_is_write: got %b expected 1", mmio_write); end
        checks++; if (mmio_address !== 32'h80) begin errors++; $display("FAIL both_w_address: got %h expected 80", mmio_address); end
        checks++; if (mmio_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL both_w_wdata: got %h expected cafe0001", mmio_wdata); end
        mmio_ack = 1'b1;
        tick(); // cycle 2
        checks++; if ({write_ack, read_ack} !== 2'b10) begin errors++; $display("FAIL both_w_ack: got %b expected 10", {write_ack, read_ack}); end
        $display("txn both write addr=80");
        mmio_ack  = 1'b0;
        write_req = 1'b0;
        tick(); // cycle 3: IDLE
        checks++; if (mmio_req !== 1'b0) begin errors++; $display("FAIL both_idle_gap: got %b expected 0", mmio_req); end
        tick(); // cycle 4: read granted
        checks++; if ({mmio_req, mmio_write} !== 2'b10) begin errors++; $display("FAIL both_second_is_read: got %b expected 10", {mmio_req, mmio_write}); end
        checks++; if (mmio_address !== 32'h44) begin errors++; $display("FAIL both_r_address: got %h expected 44", mmio_address); end
        mmio_ack   = 1'b1;
        mmio_rdata = 32'h0000_5A5A;
        tick(); // cycle 5
        checks++; if ({read_ack, write_ack} !== 2'b10) begin errors++; $display("FAIL both_r_ack: got %b expected 10", {read_ack, write_ack}); end
        checks++; if (read_data !== 32'h5A5A) begin errors++; $display("FAIL both_r_data: got %h expected 00005a5a", read_data); end
        $display("txn both read addr=44 data=%h", read_data);
        mmio_ack = 1'b0;
        read_req = 1'b0;
        tick(); // cycle 6: IDLE, raise both again
        write_req = 1'b1;
        read_req  = 1'b1;
        tick();
        checks++; if ({mmio_req, mmio_write} !== 2'b11) begin errors++; $display("FAIL both_pointer_at_write: got %b expected 11", {mmio_req, mmio_write}); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int last_cycle = 0;
        logic exp_w;
        apply_reset();
        write_address = 32'h0000_0100;
        write_data    = 32'h0000_0001;
        read_address  = 32'h0000_0200;
        write_req     = 1'b1;
        read_req      = 1'b1;
        for (int cycle = 1; cycle <= 60 && n < 8; cycle++) begin
            tick();
            exp_w = (n % 2 == 0);
            if (read_ack || write_ack) begin
                checks++; if ({write_ack, read_ack} !== {exp_w, !exp_w}) begin errors++; $display("FAIL b2b_ack_channel[%0d]: got w%b r%b expected w%b r%b", n, write_ack, read_ack, exp_w, !exp_w); end
                if (n == 0) begin
                    checks++; if (cycle !== 2) begin errors++; $display("FAIL fast_ack_latency: got %0d cycles expected 2", cycle); end
                end else begin
                    checks++; if (cycle - last_cycle !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 3", n, cycle - last_cycle); end
                end
                if (!exp_w) begin
                    checks++; if (read_data !== 32'hA000_0000 + DW'(n)) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", n, read_data, 32'hA000_0000 + DW'(n)); end
                end
                $display("txn b2b %0d %s cycle=%0d", n, write_ack ? "W" : "R", cycle);
                last_cycle = cycle;
                n++;
            end else if (mmio_req && !mmio_ack) begin
                checks++; if (mmio_write !== exp_w) begin errors++; $display("FAIL b2b_grant[%0d]: got mmio_write %b expected %b", n, mmio_write, exp_w); end
            end
            // Target acks in the first cycle it sees mmio_req.
            mmio_ack   = mmio_req;
            mmio_rdata = 32'hA000_0000 + DW'(n);
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", n); end
        write_req = 1'b0;
        read_req  = 1'b0;
        mmio_ack  = 1'b0;
    endtask

    task automatic test_stray_ack;
        int bad = 0;
        apply_reset();
        mmio_ack   = 1'b1;
        mmio_rdata = 32'h1111_2222;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mmio_req || read_ack || write_ack) bad++;
        end
        mmio_ack = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stray_ack_ignored: got %0d active cycles expected 0", bad); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL stray_ack_rdata: got %h expected 0", read_data); end
    endtask

`ifdef MMIO_ARBITER_TIMEOUT_EN
    task automatic test_timeout;
        int bad = 0;
        apply_reset();
        read_address = 32'h0000_0300;
        read_req     = 1'b1;
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (read_ack || !mmio_req || timeout_error) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_busy_hold: got %0d bad cycles expected 0", bad); end
        tick(); // cycle 17
        checks++; if (read_ack !== 1'b1) begin errors++; $display("FAIL to_read_ack: got %b expected 1", read_ack); end
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_read_data: got %h expected deadbeef", read_data); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_error_set: got %b expected 1", timeout_error); end
        checks++; if (mmio_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b expected 0", mmio_req); end
        $display("txn timeout read addr=300 data=%h", read_data);
        read_req   = 1'b0;
        mmio_ack   = 1'b1; // late ack from the target
        mmio_rdata = 32'h7777_7777;
        tick();
        tick();
        checks++; if ({read_ack, write_ack, mmio_req} !== 3'b000) begin errors++; $display("FAIL to_late_ack_ignored: got %b expected 000", {read_ack, write_ack, mmio_req}); end
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_late_ack_rdata: got %h expected deadbeef", read_data); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_error_sticky: got %b expected 1", timeout_error); end
        mmio_ack      = 1'b0;
        timeout_clear = 1'b1;
        tick();
        timeout_clear = 1'b0;
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL to_error_clear: got %b expected 0", timeout_error); end
        // A write that times out while timeout_clear is high: the set wins.
        write_address = 32'h0000_0304;
        write_req     = 1'b1;
        for (int c = 1; c <= TO; c++) tick();
        timeout_clear = 1'b1; // asserted in the expiry cycle
        tick();
        timeout_clear = 1'b0;
        write_req     = 1'b0;
        checks++; if (write_ack !== 1'b1) begin errors++; $display("FAIL to_write_ack: got %b expected 1", write_ack); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b expected 1", timeout_error); end
        $display("txn timeout write addr=304");
    endtask
`else
    task automatic test_timeout;
        int acks = 0;
        apply_reset();
        read_address = 32'h0000_0300;
        read_req     = 1'b1;
        for (int c = 0; c < 3 * TO; c++) begin
            tick();
            if (read_ack || write_ack) acks++;
            timeout_clear = (c == 5);
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL noto_no_ack: got %0d acks expected 0", acks); end
        checks++; if (mmio_req !== 1'b1) begin errors++; $display("FAIL noto_busy_waits: got %b expected 1", mmio_req); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL noto_error_tied: got %b expected 0", timeout_error); end
        read_req = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_busy;
        int bad = 0;
        apply_reset();
        write_address = 32'h0000_0400;
        write_data    = 32'h0BAD_F00D;
        write_req     = 1'b1;
        tick();
        checks++; if (mmio_req !== 1'b1) begin errors++; $display("FAIL rst_busy_entered: got %b expected 1", mmio_req); end
        tick();
        #2;
        rst_n = 1'b0;
        #1; // no clock edge in between: reset must act asynchronously
        checks++; if (all_outputs() !== '0) begin errors++; $display("FAIL rst_async_outputs: got %h expected 0", all_outputs()); end
        write_req = 1'b0;
        mmio_ack  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (read_ack || write_ack || mmio_req) bad++;
            mmio_ack = 1'b0;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_ack_after_abort: got %0d active cycles expected 0", bad); end
        read_address = 32'h0000_0408;
        read_req     = 1'b1;
        tick();
        checks++; if ({mmio_req, mmio_write} !== 2'b10) begin errors++; $display("FAIL rst_idle_regrant: got %b expected 10", {mmio_req, mmio_write}); end
        read_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_both_from_reset();
        test_back_to_back();
        test_stray_ack();
        test_timeout();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
